// File: rtl/led_blinker.sv
// Multi-channel LED blinker: shared time-base prescaler and per-channel
// OFF / ON / BLINK / ONESHOT sequencers, all outputs registered.
module led_blinker #(
  parameter int NCH      = 4,
  parameter int CW       = 17,
  parameter int PRESCALE = 100000
) (
  input  logic                                    sys_clk,
  input  logic                                    sys_rst_n,
  input  logic                                    cfg_we,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                              cfg_mode,
  input  logic [CW-1:0]                           cfg_half,
  output logic [NCH-1:0]                          led,
  output logic                                    tick,
  output logic [NCH-1:0]                          done,
  output logic [2*NCH-1:0]                        dbg_mode
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  logic [PW-1:0]  r_presc;
  logic           r_tick;
  mode_t          r_mode [NCH];
  logic [CW-1:0]  r_half [NCH];
  logic [CW-1:0]  r_cnt  [NCH];
  logic [NCH-1:0] r_led;
  logic [NCH-1:0] r_done;

  mode_t          w_mode_nxt [NCH];
  logic [CW-1:0]  w_half_nxt [NCH];
  logic [CW-1:0]  w_cnt_nxt  [NCH];
  logic [NCH-1:0] w_led_nxt;
  logic [NCH-1:0] w_done_nxt;
  logic [NCH-1:0] w_last;
  logic           w_wr_ok;
  logic           w_presc_wrap;

  assign w_wr_ok      = cfg_we && (32'(cfg_ch) < 32'(NCH));
  assign w_presc_wrap = (r_presc == PW'(PRESCALE - 1));

  // Free-running time base; writes never disturb it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick  <= w_presc_wrap;
      r_presc <= w_presc_wrap ? '0 : r_presc + PW'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_mode_nxt[i] = r_mode[i];
      w_half_nxt[i] = r_half[i];
      w_cnt_nxt[i]  = r_cnt[i];
      w_led_nxt[i]  = r_led[i];
      w_done_nxt[i] = 1'b0;
      // A half of 0 behaves as 1, so the terminal count is 0 in both cases.
      w_last[i]     = (r_half[i] <= CW'(1)) ? (r_cnt[i] == '0)
                                            : (r_cnt[i] == r_half[i] - CW'(1));
      if (w_wr_ok && (32'(cfg_ch) == 32'(i))) begin
        w_mode_nxt[i] = mode_t'(cfg_mode);
        w_half_nxt[i] = cfg_half;
        w_cnt_nxt[i]  = '0;
        w_led_nxt[i]  = (cfg_mode != 2'd0);
      end else if (r_tick) begin
        case (r_mode[i])
          MODE_BLINK: begin
            if (w_last[i]) begin
              w_cnt_nxt[i] = '0;
              w_led_nxt[i] = ~r_led[i];
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
          end
          MODE_ONESHOT: begin
            if (w_last[i]) begin
              w_cnt_nxt[i]  = '0;
              w_led_nxt[i]  = 1'b0;
              w_mode_nxt[i] = MODE_OFF;
              w_done_nxt[i] = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_mode[i] <= MODE_OFF;
        r_half[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_led  <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_mode[i] <= w_mode_nxt[i];
        r_half[i] <= w_half_nxt[i];
        r_cnt[i]  <= w_cnt_nxt[i];
      end
      r_led  <= w_led_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    dbg_mode = '0;
    for (int i = 0; i < NCH; i++) begin
      dbg_mode[2*i +: 2] = r_mode[i];
    end
  end

  assign led  = r_led;
  assign done = r_done;
  assign tick = r_tick;

endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter NCH, default 4, number of independent LED channels (1..16).
REQ-002 Parameter CW, default 17, width of per-channel half-period counter and cfg_half.
REQ-003 Parameter PRESCALE, default 100000, sys_clk cycles per time-base tick (>=2).
REQ-004 sys_clk  input  1  single clock for every register in the block.
REQ-005 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cfg_we  input  1  configuration write strobe, sampled on sys_clk rising edge.
REQ-007 cfg_ch  input  max(1,$clog2(NCH))  target channel index of the write.
REQ-008 cfg_mode  input  2  channel mode: 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT.
REQ-009 cfg_half  input  CW  half-period (BLINK) or pulse length (ONESHOT) in ticks.
REQ-010 led  output  NCH  registered per-channel LED drive, 1 = lit.
REQ-011 tick  output  1  registered one-cycle time-base strobe.
REQ-012 done  output  NCH  registered one-cycle pulse when a channel's ONESHOT ends.

Function
REQ-013 Prescaler counts 0..PRESCALE-1 and wraps to 0; tick SHALL be 1 for exactly the cycle following the prescaler value PRESCALE-1, i.e. one cycle in every PRESCALE.
REQ-014 Each channel SHALL hold registered mode (2 bits), half (CW bits) and count (CW bits); effective half = max(half,1).
REQ-015 Write (cfg_we=1, cfg_ch<NCH): next edge loads mode/half, clears count to 0 and sets led: OFF->0, ON->1, BLINK->1, ONESHOT->1; done for that channel SHALL be 0 that cycle.
REQ-016 Write with cfg_ch>=NCH SHALL be ignored; no channel state changes.
REQ-017 Write latency SHALL be one cycle: led reflects the new mode on the edge that samples cfg_we.
REQ-018 OFF and ON: led constant 0/1, count held at 0, ticks ignored.
REQ-019 BLINK, on tick: if count == effective half-1 then count<=0 and led toggles, else count increments; led period = 2*effective half ticks, 50% duty.
REQ-020 ONESHOT, on tick: if count == effective half-1 then led<=0, mode<=OFF, count<=0, done pulses 1 for one cycle; else count increments.
REQ-021 ONESHOT pulse width SHALL be effective half ticks, measured from the write to the first tick plus (effective half-1)*PRESCALE cycles; the first tick after the write counts as tick 1.
REQ-022 Write to channel c in the same cycle as tick: write wins for channel c (tick discarded for c); all other channels process the tick normally.
REQ-023 Write to a channel mid-BLINK or mid-ONESHOT SHALL abort the current operation with no done pulse.
REQ-024 count SHALL never exceed effective half-1; no overflow/wrap of count is possible.
REQ-025 Channels SHALL be fully independent; the prescaler is shared and never reset by writes.

Reset
REQ-026 While sys_rst_n=0, asynchronously: prescaler=0, tick=0, every channel mode=OFF, half=0, count=0, led=0, done=0.
REQ-027 Deassertion of sys_rst_n is assumed synchronous to sys_clk (synchronised externally); first tick SHALL occur PRESCALE cycles after the first active edge.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately; no done pulse is generated.

Verification (PRESCALE=4, NCH=4, CW=8)
REQ-029 Reset release, no writes -> tick high one cycle in every 4, led=0000, done=0000 for 100 cycles.
REQ-030 Write ch0 BLINK half=3 -> led[0]=1 next cycle, toggles every 3 ticks (12 cycles), period 24 cycles, others stay 0.
REQ-031 Write ch2 ONESHOT half=2 -> led[2]=1 for exactly 2 ticks, then led[2]=0 and done[2]=1 for one cycle in the same cycle; channel then behaves as OFF.
REQ-032 Write ch1 BLINK half=0 -> treated as half=1, led[1] toggles on every tick.
REQ-033 Write ch3 ON coincident with tick while ch0 in BLINK -> led[3]=1 next cycle, ch0 counts that tick; write with cfg_ch=5 (CW of index widened in test) or out-of-range index -> no change.
REQ-034 Assert sys_rst_n=0 mid-ONESHOT on ch2 -> led and done cleared same cycle without clock edge, no done pulse after release.
